// File: rtl/mgt_lane_sync_monitor.sv
// Lane sync monitor: comma-based LOS/ACQ/SYNC acquisition with a leaky error budget, plus error/loss counters.
// Latency: one grefclk cycle from sampled word to every output (all outputs registered).
// Backpressure: none; one word is consumed every cycle and the monitor never stalls the receiver.
module mgt_lane_sync_monitor #(
    parameter int unsigned ACQ_COMMAS = 4,
    parameter int unsigned LOS_ERRORS = 4,
    parameter int unsigned GOOD_RUN   = 16
) (
    input  logic        grefclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear_count,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic [1:0]  rx_disperr,
    input  logic [1:0]  rx_notintable,
    output logic        lane_up,
    output logic [1:0]  sync_state,
    output logic        lane_down,
    output logic [15:0] err_count,
    output logic [7:0]  loss_count
);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    localparam logic [3:0] ACQ_N = 4'(ACQ_COMMAS);
    localparam logic [3:0] LOS_N = 4'(LOS_ERRORS);
    localparam logic [7:0] RUN_N = 8'(GOOD_RUN);
    localparam logic [7:0] COMMA_CHAR = 8'hBC;

    state_t      state_q, state_d;
    logic [3:0]  acq_cnt_q, acq_cnt_d;
    logic [3:0]  err_budget_q, err_budget_d;
    logic [7:0]  run_cnt_q, run_cnt_d;
    logic        lane_up_q, lane_down_q;
    logic [15:0] err_count_q, err_count_d;
    logic [7:0]  loss_count_q, loss_count_d;

    logic        code_err;
    logic        is_comma;
    logic        lane_lost;
    logic        err_event;
    logic [3:0]  acq_inc;
    logic [3:0]  budget_inc;
    logic [7:0]  run_inc;

    // A word carrying both the comma pattern and a code error is an error only.
    assign code_err   = (|rx_disperr) | (|rx_notintable);
    assign is_comma   = (rx_charisk == 2'b01) && (rx_data[7:0] == COMMA_CHAR) && !code_err;
    assign err_event  = enable && code_err;
    assign acq_inc    = acq_cnt_q + 4'd1;
    assign budget_inc = err_budget_q + 4'd1;
    assign run_inc    = run_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        acq_cnt_d    = acq_cnt_q;
        err_budget_d = err_budget_q;
        run_cnt_d    = run_cnt_q;
        lane_lost    = 1'b0;

        if (!enable) begin
            state_d      = ST_LOS;
            acq_cnt_d    = 4'd0;
            err_budget_d = 4'd0;
            run_cnt_d    = 8'd0;
            lane_lost    = (state_q == ST_SYNC);
        end else begin
            unique case (state_q)
                ST_LOS: begin
                    if (is_comma) begin
                        if (ACQ_N <= 4'd1) begin
                            state_d      = ST_SYNC;
                            acq_cnt_d    = 4'd0;
                            err_budget_d = 4'd0;
                            run_cnt_d    = 8'd0;
                        end else begin
                            state_d   = ST_ACQ;
                            acq_cnt_d = 4'd1;
                        end
                    end
                end
                ST_ACQ: begin
                    if (code_err) begin
                        state_d   = ST_LOS;
                        acq_cnt_d = 4'd0;
                    end else if (is_comma) begin
                        if (acq_inc >= ACQ_N) begin
                            state_d      = ST_SYNC;
                            acq_cnt_d    = 4'd0;
                            err_budget_d = 4'd0;
                            run_cnt_d    = 8'd0;
                        end else begin
                            acq_cnt_d = acq_inc;
                        end
                    end
                end
                ST_SYNC: begin
                    if (code_err) begin
                        run_cnt_d = 8'd0;
                        if (budget_inc >= LOS_N) begin
                            state_d      = ST_LOS;
                            err_budget_d = 4'd0;
                            lane_lost    = 1'b1;
                        end else begin
                            err_budget_d = budget_inc;
                        end
                    end else if (run_inc >= RUN_N) begin
                        // A full good run repays one unit of the error budget.
                        run_cnt_d    = 8'd0;
                        err_budget_d = (err_budget_q != 4'd0) ? err_budget_q - 4'd1 : 4'd0;
                    end else begin
                        run_cnt_d = run_inc;
                    end
                end
                default: begin
                    state_d      = ST_LOS;
                    acq_cnt_d    = 4'd0;
                    err_budget_d = 4'd0;
                    run_cnt_d    = 8'd0;
                end
            endcase
        end
    end

    // Clear coincident with an event leaves the counter at one.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_count) begin
            err_count_d = {15'd0, err_event};
        end else if (err_event && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_comb begin
        loss_count_d = loss_count_q;
        if (clear_count) begin
            loss_count_d = {7'd0, lane_lost};
        end else if (lane_lost && (loss_count_q != 8'hFF)) begin
            loss_count_d = loss_count_q + 8'd1;
        end
    end

    always_ff @(posedge grefclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOS;
            acq_cnt_q    <= 4'd0;
            err_budget_q <= 4'd0;
            run_cnt_q    <= 8'd0;
            lane_up_q    <= 1'b0;
            lane_down_q  <= 1'b0;
            err_count_q  <= 16'd0;
            loss_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            acq_cnt_q    <= acq_cnt_d;
            err_budget_q <= err_budget_d;
            run_cnt_q    <= run_cnt_d;
            lane_up_q    <= (state_d == ST_SYNC);
            lane_down_q  <= lane_lost;
            err_count_q  <= err_count_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign lane_up    = lane_up_q;
    assign sync_state = state_q;
    assign lane_down  = lane_down_q;
    assign err_count  = err_count_q;
    assign loss_count = loss_count_q;

endmodule
